// File: rtl/seq_mul32_pkg.sv
// rtl/seq_mul32_pkg.sv - shared state encoding and constants for seq_mul32
package seq_mul32_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } mul_state_t;

   localparam int MUL_ITER = 32;

endpackage

// File: rtl/cla32.sv
// rtl/cla32.sv - 32-bit carry-lookahead adder, 4-bit lookahead groups
module cla32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ci,
   output logic [31:0] s,
   output logic        co
);

   logic [31:0] w_g;
   logic [31:0] w_p;
   logic [32:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // carries computed per 4-bit group from the group's carry-in
   always_comb begin
      w_c = '0;
      w_c[0] = ci;
      for (int k = 0; k < 8; k++) begin
         w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
         w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
         w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
         w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      end
   end

   assign s  = w_p ^ w_c[31:0];
   assign co = w_c[32];

endmodule

// File: rtl/neg64.sv
// rtl/neg64.sv - 64-bit conditional two's-complement negation
module neg64 (
   input  logic        i_en,
   input  logic [63:0] i_x,
   output logic [63:0] o_y
);

   assign o_y = i_en ? (~i_x + 64'd1) : i_x;

endmodule

// File: rtl/seq_mul32.sv
// rtl/seq_mul32.sv - iterative shift-add 32x32->64 multiplier (MULT/MULTU)
import seq_mul32_pkg::*;

module seq_mul32 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mul_state_t         r_state;
   mul_state_t         w_next;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_neg;
   logic               r_ready;

   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH-1:0]   w_sum;
   logic               w_co;
   logic [2*WIDTH-1:0] w_fixed;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic               w_last;

   // magnitudes of the operands; 0x80000000 stays as-is and is read as unsigned
   assign w_abs_a = (is_signed & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign w_abs_b = (is_signed & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

   assign w_addend = r_lo[0] ? r_mcand : '0;
   assign w_last   = (r_cnt == CNT_W'(MUL_ITER - 1));

   cla32 u_cla32 (
      .a  (r_hi),
      .b  (w_addend),
      .ci (1'b0),
      .s  (w_sum),
      .co (w_co)
   );

   neg64 u_neg64 (
      .i_en (r_neg),
      .i_x  ({r_hi, r_lo}),
      .o_y  (w_fixed)
   );

   // state register
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state: one pass through RUN per partial product, then sign fix-up
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // datapath: load magnitudes, accumulate-and-shift, then apply sign
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
         r_neg   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mcand <= w_abs_a;
                  r_lo    <= w_abs_b;
                  r_hi    <= '0;
                  r_cnt   <= '0;
                  r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               end
            end
            S_RUN: begin
               // adder carry-out becomes the new top bit of hi
               r_hi  <= {w_co, w_sum[WIDTH-1:1]};
               r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
               r_cnt <= r_cnt + CNT_W'(1);
            end
            S_FIX: begin
               {r_hi, r_lo} <= w_fixed;
            end
            default: ;
         endcase
      end
   end

   // ready is a registered decode of DONE
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) r_ready <= 1'b0;
      else       r_ready <= (r_state == S_DONE);
   end

   assign busy  = (r_state == S_RUN) | (r_state == S_FIX);
   assign ready = r_ready;
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule
